// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter/sequencer sharing one register bank among NUM_REQ requesters
//
// Each accepted request becomes exactly one bank access (IDLE/RESP -> ACCESS -> RESP).
// The completion pulse and any read data return on the cycle after the access.
//
// Optional feature: define REG_BANK_ARB_WRITE_PROTECT_EN so that only requester 0 may write.
// A write from any other requester still runs the full sequence, but it never enables a
// register and it completes with o_resp_error set. Without the macro, o_resp_error is tied to 0.
//
// Ports:
//   i_clock               sole clock, rising edge
//   i_reset               synchronous, active-high
//   i_req_valid           per-requester request pending
//   o_req_ready           one-hot grant; the handshake completes on valid & ready at a clock edge
//   i_req_write_or_read   per-requester 1 = write, 0 = read
//   i_req_addr            packed; requester i uses [i*ADDR_WIDTH +: ADDR_WIDTH]
//   i_req_write_data      packed; requester i uses [i*8 +: 8]
//   o_resp_valid          one-cycle completion pulse to the originating requester
//   o_resp_read_data      read result while a response is valid; 0 for writes
//   o_resp_error          rejected-write pulse, coincident with o_resp_valid
//   o_bank_enable         one-hot register enable, active only in ACCESS
//   o_bank_write_or_read  shared write/read strobe to the bank
//   o_bank_write_data     shared write data to the bank
//   i_bank_read_data      OR of all register read outputs
module reg_bank_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   output logic [NUM_REQ-1:0]             o_req_ready,
   input  logic [NUM_REQ-1:0]             i_req_write_or_read,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
   input  logic [NUM_REQ*8-1:0]           i_req_write_data,
   output logic [NUM_REQ-1:0]             o_resp_valid,
   output logic [7:0]                     o_resp_read_data,
   output logic                           o_resp_error,
   output logic [2**ADDR_WIDTH-1:0]       o_bank_enable,
   output logic                           o_bank_write_or_read,
   output logic [7:0]                     o_bank_write_data,
   input  logic [7:0]                     i_bank_read_data
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int IDXW  = $clog2(NUM_REQ);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]            r_state;
   logic [IDXW-1:0]       r_rr_ptr;
   logic [IDXW-1:0]       r_win;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wr;
   logic [7:0]            r_wdata;
   logic [7:0]            r_rdata;
   logic                  w_arb_en;
   logic                  w_any;
   logic [IDXW-1:0]       w_win;
   logic                  w_access;
   logic                  w_resp;
   logic                  w_blocked;

   // Requester index offset positions after ptr, wrapping modulo NUM_REQ.
   function automatic logic [IDXW-1:0] f_rr_idx(input logic [IDXW-1:0] ptr, input int off);
      int s;
      s = int'(ptr) + off;
      return IDXW'(s >= NUM_REQ ? s - NUM_REQ : s);
   endfunction

   // Arbitration runs in IDLE and RESP (any non-ACCESS state) and is silenced during reset.
   assign w_arb_en = ~i_reset & (r_state != S_ACCESS);
   assign w_access = ~i_reset & (r_state == S_ACCESS);
   assign w_resp   = ~i_reset & (r_state == S_RESP);

   // Scan from the farthest position back to rr_ptr so the nearest valid requester wins.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_req_valid[f_rr_idx(r_rr_ptr, i)]) begin
            w_any = 1'b1;
            w_win = f_rr_idx(r_rr_ptr, i);
         end
      end
   end

`ifdef REG_BANK_ARB_WRITE_PROTECT_EN
   logic r_err;
   assign w_blocked = r_wr & (r_win != '0);
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_err <= 1'b0;
      else if (r_state == S_ACCESS)
         r_err <= w_blocked;
   end
   assign o_resp_error = w_resp & r_err;
`else
   assign w_blocked    = 1'b0;
   assign o_resp_error = 1'b0;
`endif

   assign o_req_ready          = (w_arb_en & w_any) ? NUM_REQ'(1) << w_win : '0;
   assign o_bank_enable        = (w_access & ~w_blocked) ? DEPTH'(1) << r_addr : '0;
   assign o_bank_write_or_read = w_access & r_wr;
   assign o_bank_write_data    = w_access ? r_wdata : 8'h00;
   assign o_resp_valid         = w_resp ? NUM_REQ'(1) << r_win : '0;
   assign o_resp_read_data     = w_resp ? r_rdata : 8'h00;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_win    <= '0;
         r_addr   <= '0;
         r_wr     <= 1'b0;
         r_wdata  <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            S_ACCESS: begin
               r_state  <= S_RESP;
               r_rr_ptr <= f_rr_idx(r_win, 1);
               // Writes, including rejected ones, always respond with zero data.
               r_rdata  <= (r_wr | w_blocked) ? 8'h00 : i_bank_read_data;
            end
            default: begin
               r_state <= w_any ? S_ACCESS : S_IDLE;
               if (w_any) begin
                  r_win   <= w_win;
                  r_addr  <= i_req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                  r_wr    <= i_req_write_or_read[w_win];
                  r_wdata <= i_req_write_data[w_win*8 +: 8];
               end
            end
         endcase
      end
   end
endmodule
